// File: rtl/ui_addsub_pipe.sv
// Pipelined unsigned add/subtract with carry/borrow flag, optional saturation,
// valid/ready flow control and a saturating overflow-event counter.
module ui_addsub_pipe #(
   parameter int N      = 64,
   parameter int STAGES = 2,
   parameter int CW     = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          op,
   input  logic          sat,
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  c,
   output logic          ovf,
   output logic [CW-1:0] ovf_cnt,
   input  logic          cnt_clr
);

   localparam int LAST = STAGES - 1;

   logic [N:0]    ext_d;
   logic [N-1:0]  res_d;
   logic          adv;

   logic          valid_q [STAGES];
   logic [N-1:0]  c_q     [STAGES];
   logic          ovf_q   [STAGES];

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // N+1-bit arithmetic: the top bit is the carry for add and the borrow for sub.
   always_comb begin
      ext_d = {1'b0, a} + {1'b0, b};
      if (op) begin
         ext_d = {1'b0, a} - {1'b0, b};
      end
   end

   always_comb begin
      res_d = ext_d[N-1:0];
      if (sat && ext_d[N]) begin
         res_d = op ? '0 : '1;
      end
   end

   // A stalled last stage freezes the whole chain; interior bubbles are kept.
   assign adv      = out_ready | ~valid_q[LAST];
   assign in_ready = adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            valid_q[i] <= 1'b0;
            c_q[i]     <= '0;
            ovf_q[i]   <= 1'b0;
         end
      end else if (adv) begin
         valid_q[0] <= in_valid;
         if (in_valid) begin
            c_q[0]   <= res_d;
            ovf_q[0] <= ext_d[N];
         end
         for (int i = 1; i < STAGES; i++) begin
            valid_q[i] <= valid_q[i-1];
            c_q[i]     <= c_q[i-1];
            ovf_q[i]   <= ovf_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[LAST];
   assign c         = c_q[LAST];
   assign ovf       = ovf_q[LAST];

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (valid_q[LAST] && out_ready && ovf_q[LAST] && (cnt_q != {CW{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ovf_cnt = cnt_q;

endmodule

// File: tb/tb_ui_addsub_pipe.sv
// Directed bench for ui_addsub_pipe at N=8, STAGES=2, CW=2.
module tb_ui_addsub_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic       op;
   logic       sat;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] c;
   logic       ovf;
   logic [1:0] ovf_cnt;
   logic       cnt_clr;

   int n_cmp = 0;
   int n_err = 0;

   ui_addsub_pipe #(.N(8), .STAGES(2), .CW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .sat       (sat),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .ovf       (ovf),
      .ovf_cnt   (ovf_cnt),
      .cnt_clr   (cnt_clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic o, input logic s,
                        input logic [7:0] av, input logic [7:0] bv);
      in_valid = v; op = o; sat = s; a = av; b = bv;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; drive(0, 0, 0, 8'd0, 8'd0); out_ready = 1'b0; cnt_clr = 1'b0;
      #13;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_cmp++; if (c !== 8'd0 || ovf !== 1'b0) begin n_err++; $display("FAIL reset_c_ovf got %0d/%b want 0/0", c, ovf); end
      n_cmp++; if (ovf_cnt !== 2'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", ovf_cnt); end
      tick();
      rst_n = 1'b1;
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_add_wrap();
      out_ready = 1'b1;
      drive(1, 0, 0, 8'd200, 8'd100);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL add_in_ready got %b want 1", in_ready); end
      tick();
      drive(0, 1, 1, 8'd1, 8'd2);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_early_valid got %b want 0", out_valid); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || c !== 8'd44 || ovf !== 1'b1)
         begin n_err++; $display("FAIL add_wrap got v=%b c=%0d ovf=%b want v=1 c=44 ovf=1", out_valid, c, ovf); end
      n_cmp++; if (ovf_cnt !== 2'd0) begin n_err++; $display("FAIL add_cnt_before got %0d want 0", ovf_cnt); end
      tick();
      n_cmp++; if (ovf_cnt !== 2'd1) begin n_err++; $display("FAIL add_cnt_after got %0d want 1", ovf_cnt); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_single_beat got %b want 0", out_valid); end
   endtask

   task automatic test_sat();
      logic       v_op  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic       v_sat [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [7:0] v_a   [4] = '{8'd200, 8'd5, 8'd9, 8'd5};
      logic [7:0] v_b   [4] = '{8'd100, 8'd9, 8'd5, 8'd9};
      logic [7:0] e_c   [4] = '{8'd255, 8'd0, 8'd4, 8'd252};
      logic       e_o   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(1, v_op[i], v_sat[i], v_a[i], v_b[i]);
         else       drive(0, 0, 0, 8'd0, 8'd0);
         #1;
         if (i >= 2) begin
            n_cmp++;
            if (out_valid !== 1'b1 || c !== e_c[i-2] || ovf !== e_o[i-2]) begin
               n_err++;
               $display("FAIL sat_beat%0d got v=%b c=%0d ovf=%b want v=1 c=%0d ovf=%b",
                        i-2, out_valid, c, ovf, e_c[i-2], e_o[i-2]);
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] expq [$];
      int sent = 0, rcvd = 0, ex, s;
      bit started = 0;
      logic [7:0] ra, rb;
      logic ro, rs;
      logic [8:0] e;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && rcvd < 16; cyc++) begin
         if (sent < 16) begin
            ra = 8'($urandom); rb = 8'($urandom); ro = 1'($urandom); rs = 1'($urandom);
            drive(1, ro, rs, ra, rb);
            if (!ro) begin
               s = int'(ra) + int'(rb);
               ex = (s > 255) ? (rs ? 255 : s - 256) : s;
               e = {ex[7:0], (s > 255) ? 1'b1 : 1'b0};
            end else begin
               s = int'(ra) - int'(rb);
               ex = (s < 0) ? (rs ? 0 : s + 256) : s;
               e = {ex[7:0], (s < 0) ? 1'b1 : 1'b0};
            end
            expq.push_back(e);
            sent++;
         end else begin
            drive(0, 0, 0, 8'd0, 8'd0);
         end
         #1;
         n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready cyc%0d got %b want 1", cyc, in_ready); end
         if (out_valid === 1'b1) begin
            started = 1;
            e = expq.pop_front();
            n_cmp++;
            if (c !== e[8:1] || ovf !== e[0]) begin
               n_err++;
               $display("FAIL b2b_result%0d got c=%0d ovf=%b want c=%0d ovf=%b", rcvd, c, ovf, e[8:1], e[0]);
            end
            rcvd++;
         end else if (started) begin
            n_cmp++; n_err++;
            $display("FAIL b2b_gap after %0d results got out_valid=0 want 1", rcvd);
         end
         tick();
      end
      n_cmp++; if (rcvd != 16) begin n_err++; $display("FAIL b2b_count got %0d want 16", rcvd); end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b1;
      drive(1, 0, 0, 8'd200, 8'd100); tick();
      drive(1, 0, 0, 8'd250, 8'd250); tick();
      drive(0, 0, 0, 8'd0, 8'd0);
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || c !== 8'd0 || ovf !== 1'b0)
         begin n_err++; $display("FAIL rst_mid_out got v=%b c=%0d ovf=%b want 0/0/0", out_valid, c, ovf); end
      n_cmp++; if (ovf_cnt !== 2'd0) begin n_err++; $display("FAIL rst_mid_cnt got %0d want 0", ovf_cnt); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_stale cyc%0d got %b want 0", i, out_valid); end
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      drive(1, 0, 0, 8'd200, 8'd100); tick();
      drive(1, 0, 0, 8'd30, 8'd40);  tick();
      drive(1, 0, 0, 8'd50, 8'd60);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || c !== 8'd44 || ovf !== 1'b1 || ovf_cnt !== 2'd0) begin
            n_err++;
            $display("FAIL stall_cyc%0d got rdy=%b v=%b c=%0d ovf=%b cnt=%0d want 0/1/44/1/0",
                     i, in_ready, out_valid, c, ovf, ovf_cnt);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1 || c !== 8'd44) begin n_err++; $display("FAIL stall_release got rdy=%b c=%0d want 1/44", in_ready, c); end
      tick();
      drive(0, 0, 0, 8'd0, 8'd0);
      n_cmp++; if (ovf_cnt !== 2'd1) begin n_err++; $display("FAIL stall_cnt got %0d want 1", ovf_cnt); end
      n_cmp++; if (out_valid !== 1'b1 || c !== 8'd70 || ovf !== 1'b0) begin n_err++; $display("FAIL stall_beat2 got v=%b c=%0d ovf=%b want 1/70/0", out_valid, c, ovf); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || c !== 8'd110) begin n_err++; $display("FAIL stall_beat3 got v=%b c=%0d want 1/110", out_valid, c); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_dup got %b want 0", out_valid); end
   endtask

   task automatic test_cnt_sat();
      out_ready = 1'b1;
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      n_cmp++; if (ovf_cnt !== 2'd0) begin n_err++; $display("FAIL cnt_clr_plain got %0d want 0", ovf_cnt); end
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 0, 8'd3, 8'd7);
         tick();
      end
      drive(0, 0, 0, 8'd0, 8'd0);
      tick(); tick();
      n_cmp++; if (ovf_cnt !== 2'd3) begin n_err++; $display("FAIL cnt_sat got %0d want 3", ovf_cnt); end
      drive(1, 0, 1, 8'd128, 8'd128); tick();
      drive(0, 0, 0, 8'd0, 8'd0);     tick();
      cnt_clr = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b1 || ovf !== 1'b1 || c !== 8'd255) begin n_err++; $display("FAIL cnt_clr_beat got v=%b ovf=%b c=%0d want 1/1/255", out_valid, ovf, c); end
      tick();
      cnt_clr = 1'b0;
      n_cmp++; if (ovf_cnt !== 2'd0) begin n_err++; $display("FAIL cnt_clr_prio got %0d want 0", ovf_cnt); end
   endtask

   initial begin
      test_reset();
      test_add_wrap();
      test_sat();
      test_back_to_back();
      test_reset_midflight();
      test_stall();
      test_cnt_sat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
